// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/grant bundle between requesters and the memory port arbiter
interface mem_port_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output sel,
        output busy,
        output timeout
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin four-way memory port arbiter with hold limit and turnaround gap
module mem_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [3:0]         gnt_q, gnt_nxt;
    logic [1:0]         sel_q, sel_nxt;
    logic [1:0]         ptr_q, ptr_nxt;
    logic [CNT_W-1:0]   hold_q, hold_nxt;
    logic               timeout_q, timeout_nxt;

    logic [1:0]         winner;
    logic [1:0]         scan_idx;
    logic               found;
    logic               owner_req;
    logic               at_limit;
    logic               release_now;

    // Release is evaluated only in GRANT; done outside GRANT is never looked at.
    assign owner_req   = bus.req[sel_q];
    assign at_limit    = (hold_q == CNT_W'(MAX_HOLD - 1));
    assign release_now = bus.done || !owner_req || at_limit;

    // Round-robin scan starting at ptr; first requesting index wins.
    always_comb begin
        winner   = ptr_q;
        scan_idx = ptr_q;
        found    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (!found && bus.req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // State register plus the registered outputs and bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'd0;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            gnt_q     <= gnt_nxt;
            sel_q     <= sel_nxt;
            ptr_q     <= ptr_nxt;
            hold_q    <= hold_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    // Next-state: arbitrate from IDLE, fall back to IDLE on any release cause.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found)       state_nxt = GRANT;
            GRANT:   if (release_now) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Register next values; IDLE always drives gnt low so every grant is followed by a gap cycle.
    always_comb begin
        gnt_nxt     = gnt_q;
        sel_nxt     = sel_q;
        ptr_nxt     = ptr_q;
        hold_nxt    = hold_q;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                if (found) begin
                    gnt_nxt  = 4'b0001 << winner;
                    sel_nxt  = winner;
                    hold_nxt = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    gnt_nxt     = 4'b0000;
                    ptr_nxt     = sel_q + 2'd1;
                    hold_nxt    = '0;
                    timeout_nxt = at_limit && !bus.done && owner_req;
                end else begin
                    hold_nxt = hold_q + 1'b1;
                end
            end
            default: begin
                gnt_nxt = 4'b0000;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = (state == GRANT);
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t exp_q[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied at the falling edge; expected outputs after the following rising edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic dn,
                        input logic [3:0] eg, input logic [1:0] es,
                        input logic eb, input logic et);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.done = dn;
        e.gnt     = eg;
        e.sel     = es;
        e.busy    = eb;
        e.timeout = et;
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per cycle and compare, plus grant invariants.
    always @(posedge clk) begin
        exp_t e;
        exp_t a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.gnt, bus.sel, bus.busy, bus.timeout};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL outputs t=%0t got gnt=%b sel=%0d busy=%b timeout=%b want gnt=%b sel=%0d busy=%b timeout=%b",
                         $time, a.gnt, a.sel, a.busy, a.timeout, e.gnt, e.sel, e.busy, e.timeout);
            end
            total++;
            if ((bus.gnt != 4'b0000 && bus.gnt !== (4'b0001 << bus.sel)) ||
                (bus.busy !== (bus.gnt != 4'b0000))) begin
                bad++;
                $display("FAIL invariant t=%0t got gnt=%b sel=%0d busy=%b want onehot(sel) or zero with busy==|gnt",
                         $time, bus.gnt, bus.sel, bus.busy);
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        bus.req  = 4'b0000;
        bus.done = 1'b0;

        // Reset with all requesters pending, then first grant to 0.
        step(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0);
        step(1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        // Round-robin, done in the third grant cycle of each owner.
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0);
        step(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
        step(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0);
        step(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        // Owner 0 drops its request in its first grant cycle.
        step(0, 4'b0100, 0, 4'b0000, 2'd0, 0, 0);
        // Hold limit: four grant cycles, then a single timeout pulse.
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0000, 2'd2, 0, 1);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        // done coinciding with the hold limit suppresses timeout.
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        step(0, 4'b0100, 1, 4'b0000, 2'd2, 0, 0);
        // Pointer at 3 wraps to 0.
        step(0, 4'b0011, 0, 4'b0001, 2'd0, 1, 0);
        step(0, 4'b0010, 0, 4'b0000, 2'd0, 0, 0);
        // done in IDLE is ignored; non-owner change ignored; owner 1 drops in 2nd cycle.
        step(0, 4'b0010, 1, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0011, 0, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0001, 0, 4'b0000, 2'd1, 0, 0);
        // ptr now 2: requesters 1 and 3, 3 wins.
        step(0, 4'b1010, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1010, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1010, 0, 4'b1000, 2'd3, 1, 0);
        step(0, 4'b1010, 0, 4'b1000, 2'd3, 1, 0);
        // Reset at the hold-limit cycle: no timeout, pointer back to 0.
        step(1, 4'b1010, 0, 4'b0000, 2'd0, 0, 0);
        step(0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
        step(0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
        step(0, 4'b0000, 1, 4'b0000, 2'd1, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
